cordic_iter: RTL and testbench

//  Parametrised iterative CORDIC engine and successor to the fixed 32-bit sin/cos unit.
//  - Rotation mode: rotates an input vector (x,y) by a binary angle.
//  - Vectoring mode: returns the magnitude and atan2 of (x,y).
//  - One micro-rotation per clock. Valid/ready handshakes on both sides.
//  - Used by the DSP datapath and the NCO/phase-detect logic.

---
 rtl/cordic_iter.sv | 183 ++++++++++++++++++
 tb/tb_cordic_iter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter.sv
// cordic_iter: iterative CORDIC engine (rotation / vectoring), one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a 1/K scaling step for unity-gain outputs.
module cordic_iter #(
    parameter int WIDTH = 32,
    parameter int ITERS = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] angle_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] angle_out
);
    localparam int DW = WIDTH + 2;
    localparam int IW = $clog2(ITERS + 1);
    localparam logic [WIDTH-1:0] HALF_TURN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ROTATE = 2'd1;
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [1:0] SCALE  = 2'd2;
`endif
    localparam logic [1:0] DONE   = 2'd3;

    // atan(2^-i) as a binary angle, full turn = 2^32
    function automatic logic [31:0] atan32(input int idx);
        case (idx)
            0:  atan32 = 32'h2000_0000;  1:  atan32 = 32'h12E4_051E;
            2:  atan32 = 32'h09FB_385B;  3:  atan32 = 32'h0511_11D4;
            4:  atan32 = 32'h028B_0D43;  5:  atan32 = 32'h0145_D7E1;
            6:  atan32 = 32'h00A2_F61E;  7:  atan32 = 32'h0051_7C55;
            8:  atan32 = 32'h0028_BE53;  9:  atan32 = 32'h0014_5F2F;
            10: atan32 = 32'h000A_2F98;  11: atan32 = 32'h0005_17CC;
            12: atan32 = 32'h0002_8BE6;  13: atan32 = 32'h0001_45F3;
            14: atan32 = 32'h0000_A2FA;  15: atan32 = 32'h0000_517D;
            16: atan32 = 32'h0000_28BE;  17: atan32 = 32'h0000_145F;
            18: atan32 = 32'h0000_0A30;  19: atan32 = 32'h0000_0518;
            20: atan32 = 32'h0000_028C;  21: atan32 = 32'h0000_0146;
            22: atan32 = 32'h0000_00A3;  23: atan32 = 32'h0000_0051;
            24: atan32 = 32'h0000_0029;  25: atan32 = 32'h0000_0014;
            26: atan32 = 32'h0000_000A;  27: atan32 = 32'h0000_0005;
            28: atan32 = 32'h0000_0003;  29: atan32 = 32'h0000_0001;
            30: atan32 = 32'h0000_0001;
            default: atan32 = 32'h0000_0000;
        endcase
    endfunction

    logic [WIDTH-1:0] atan_tab [0:ITERS-1];
    generate
        for (genvar gi = 0; gi < ITERS; gi++) begin : g_atan
            localparam logic [31:0] FULL = atan32(gi);
            assign atan_tab[gi] = FULL[31 -: WIDTH];
        end
    endgenerate

    logic [1:0]              state_reg;
    logic [IW-1:0]           iter_reg;
    logic                    mode_reg;
    logic signed [DW-1:0]    x_reg, y_reg;
    logic [WIDTH-1:0]        z_reg;
    logic [WIDTH-1:0]        x_out_reg, y_out_reg, angle_out_reg;

    assign in_ready  = (state_reg == IDLE) && !reset;
    assign out_valid = (state_reg == DONE);
    assign x_out     = x_out_reg;
    assign y_out     = y_out_reg;
    assign angle_out = angle_out_reg;

    // Quadrant pre-rotation folds the input into the +/-90 degree convergence range
    logic signed [DW-1:0] x_ext, y_ext, x_pre, y_pre;
    logic [WIDTH-1:0]     z_pre;
    logic                 flip;
    always_comb begin
        x_ext = {{2{x_in[WIDTH-1]}}, x_in};
        y_ext = {{2{y_in[WIDTH-1]}}, y_in};
        flip  = mode ? x_in[WIDTH-1] : (angle_in[WIDTH-1] ^ angle_in[WIDTH-2]);
        x_pre = flip ? -x_ext : x_ext;
        y_pre = flip ? -y_ext : y_ext;
        if (mode)
            z_pre = flip ? HALF_TURN : '0;
        else
            z_pre = flip ? (angle_in - HALF_TURN) : angle_in;
    end

    logic [WIDTH-1:0] atan_sel;
    always_comb begin
        atan_sel = '0;
        for (int k = 0; k < ITERS; k++)
            if (iter_reg == IW'(k)) atan_sel = atan_tab[k];
    end

    logic                 dir;
    logic signed [DW-1:0] x_sh, y_sh, x_rot, y_rot;
    logic [WIDTH-1:0]     z_rot;
    always_comb begin
        dir   = mode_reg ? y_reg[DW-1] : ~z_reg[WIDTH-1];
        x_sh  = x_reg >>> iter_reg;
        y_sh  = y_reg >>> iter_reg;
        x_rot = dir ? (x_reg - y_sh) : (x_reg + y_sh);
        y_rot = dir ? (y_reg + x_sh) : (y_reg - x_sh);
        z_rot = dir ? (z_reg - atan_sel) : (z_reg + atan_sel);
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam real INV_K = 0.6072529350;
    localparam logic [WIDTH-1:0] INV_K_COEF = WIDTH'(longint'(INV_K * (2.0 ** WIDTH)));
    localparam int PW = DW + WIDTH + 1;
    localparam logic signed [PW-1:0] ROUND_HALF = PW'(1) <<< (WIDTH - 1);

    logic signed [PW-1:0] x_prod, y_prod;
    logic signed [DW-1:0] x_scl, y_scl;
    always_comb begin
        x_prod = PW'(x_reg) * PW'($signed({1'b0, INV_K_COEF}));
        y_prod = PW'(y_reg) * PW'($signed({1'b0, INV_K_COEF}));
        x_scl  = DW'((x_prod + ROUND_HALF) >>> WIDTH);
        y_scl  = DW'((y_prod + ROUND_HALF) >>> WIDTH);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            iter_reg      <= '0;
            mode_reg      <= 1'b0;
            x_reg         <= '0;
            y_reg         <= '0;
            z_reg         <= '0;
            x_out_reg     <= '0;
            y_out_reg     <= '0;
            angle_out_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mode_reg  <= mode;
                        x_reg     <= x_pre;
                        y_reg     <= y_pre;
                        z_reg     <= z_pre;
                        iter_reg  <= '0;
                        state_reg <= ROTATE;
                    end
                end
                ROTATE: begin
                    // The pass after the last micro-rotation hands the converged vector on
                    if (iter_reg == IW'(ITERS)) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state_reg     <= SCALE;
`else
                        x_out_reg     <= x_reg[WIDTH-1:0];
                        y_out_reg     <= y_reg[WIDTH-1:0];
                        angle_out_reg <= z_reg;
                        state_reg     <= DONE;
`endif
                    end else begin
                        x_reg    <= x_rot;
                        y_reg    <= y_rot;
                        z_reg    <= z_rot;
                        iter_reg <= iter_reg + IW'(1);
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                SCALE: begin
                    x_out_reg     <= x_scl[WIDTH-1:0];
                    y_out_reg     <= y_scl[WIDTH-1:0];
                    angle_out_reg <= z_reg;
                    state_reg     <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: directed scoreboard bench for cordic_iter at ITERS=24 and ITERS=8.
// Expected values come from a floating-point rotation/atan2 model.
`timescale 1ns/1ps
module tb_cordic_iter;
    localparam int W   = 32;
    localparam int IT  = 24;
    localparam int IT8 = 8;
`ifdef CORDIC_GAIN_COMP_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif
    localparam int  LAT    = COMP ? IT + 2 : IT + 1;
    localparam int  LAT8   = COMP ? IT8 + 2 : IT8 + 1;
    localparam int  TOL    = COMP ? 'h400 : 'h800;
    localparam int  TOL_A  = 'h400;
    localparam int  TOL_V  = 'h2000;
    // 8 micro-rotations leave up to atan(2^-7) of residual angle
    localparam int  TOL8   = 1 << 24;
    localparam real PI     = 3.14159265358979323846;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset, in_valid, in_valid8, mode, out_ready, out_ready8;
    logic [W-1:0] x_in, y_in, angle_in;
    logic         in_ready, out_valid, in_ready8, out_valid8;
    logic [W-1:0] x_out, y_out, angle_out, x_out8, y_out8, angle_out8;

    cordic_iter #(.WIDTH(W), .ITERS(IT)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .angle_out(angle_out)
    );

    cordic_iter #(.WIDTH(W), .ITERS(IT8)) u_dut8 (
        .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .mode(mode), .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .x_out(x_out8), .y_out(y_out8), .angle_out(angle_out8)
    );

    typedef struct {
        logic [W-1:0] x, y, a;
        int           tol_xy, tol_a;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int errors  = 0;

    function automatic real kgain(input int n);
        real k;
        k = 1.0;
        for (int i = 0; i < n; i++) k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
        return k;
    endfunction

    function automatic exp_t model(input bit md, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] a, input real gain, input int tol_xy, input int tol_a);
        real xr, yr, th, xo, yo, ao;
        exp_t want;
        xr = real'($signed(x)) / 1073741824.0;
        yr = real'($signed(y)) / 1073741824.0;
        if (!md) begin
            th = real'(a) / 4294967296.0 * 2.0 * PI;
            xo = gain * (xr * $cos(th) - yr * $sin(th));
            yo = gain * (xr * $sin(th) + yr * $cos(th));
            ao = 0.0;
        end else begin
            xo = gain * $sqrt(xr * xr + yr * yr);
            yo = 0.0;
            ao = $atan2(yr, xr) / (2.0 * PI) * 4294967296.0;
        end
        want.x = 32'(longint'(xo * 1073741824.0));
        want.y = 32'(longint'(yo * 1073741824.0));
        want.a = 32'(longint'(ao));
        want.tol_xy = tol_xy;
        want.tol_a  = tol_a;
        return want;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic want);
        vectors++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
        vectors++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int want);
        vectors++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic check_tol(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want, input int tol);
        logic [W-1:0] d;
        longint ad;
        d  = obs - want;
        ad = longint'($signed(d));
        if (ad < 0) ad = -ad;
        vectors++;
        assert (ad <= longint'(tol)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h tol=%0d", tag, obs, want, tol);
        end
    endtask

    // Drive one request, wait for the result, check latency and pop-compare the scoreboard
    task automatic send(input string tag, input bit use8, input bit md, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] a, input real gain,
                        input int tol_xy, input int tol_a, input int lat_want);
        int   lat;
        exp_t want;
        logic [W-1:0] ox, oy, oa;
        sb.push_back(model(md, x, y, a, gain, tol_xy, tol_a));
        @(negedge clock);
        mode = md; x_in = x; y_in = y; angle_in = a;
        if (use8) in_valid8 = 1'b1; else in_valid = 1'b1;
        check_bit({tag, "_in_ready"}, use8 ? in_ready8 : in_ready, 1'b1);
        @(posedge clock); #1;
        in_valid = 1'b0; in_valid8 = 1'b0;
        lat = 0;
        while (!(use8 ? out_valid8 : out_valid) && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        check_int({tag, "_latency"}, lat, lat_want);
        want = sb.pop_front();
        ox = use8 ? x_out8 : x_out;
        oy = use8 ? y_out8 : y_out;
        oa = use8 ? angle_out8 : angle_out;
        check_tol({tag, "_x"}, ox, want.x, want.tol_xy);
        check_tol({tag, "_y"}, oy, want.y, want.tol_xy);
        check_tol({tag, "_angle"}, oa, want.a, want.tol_a);
        $display("txn %s mode=%0d in=(%h,%h,%h) out=(%h,%h,%h) want=(%h,%h,%h) lat=%0d",
                 tag, md, x, y, a, ox, oy, oa, want.x, want.y, want.a, lat);
    endtask

    task automatic release_out(input string tag, input bit use8);
        @(negedge clock);
        if (use8) out_ready8 = 1'b1; else out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0; out_ready8 = 1'b0;
        check_bit({tag, "_rel_out_valid"}, use8 ? out_valid8 : out_valid, 1'b0);
        check_bit({tag, "_rel_in_ready"}, use8 ? in_ready8 : in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        real g24, g8;
        logic [W-1:0] cap_x, cap_y, cap_a;
        g24 = COMP ? 1.0 : kgain(IT);
        g8  = COMP ? 1.0 : kgain(IT8);
        reset = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0; out_ready8 = 1'b0;
        mode = 1'b0; x_in = '0; y_in = '0; angle_in = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_word("rst_x_out", x_out, '0);
        check_word("rst_y_out", y_out, '0);
        check_word("rst_angle_out", angle_out, '0);
        reset = 1'b0;
        #1;
        check_bit("post_rst_in_ready", in_ready, 1'b1);

        // Rotation -90 and +45 degrees
        send("rot_m90", 1'b0, 1'b0, 32'h4000_0000, 32'h0, 32'hC000_0000, g24, TOL, TOL_A, LAT);
        release_out("rot_m90", 1'b0);
        send("rot_45", 1'b0, 1'b0, 32'h4000_0000, 32'h0, 32'h2000_0000, g24, TOL, TOL_A, LAT);

        // Backpressure: hold result 10 cycles while a stray request is offered
        cap_x = x_out; cap_y = y_out; cap_a = angle_out;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            in_valid = 1'b1; mode = 1'b1; x_in = 32'h1234_5678; y_in = 32'h0765_4321;
            @(posedge clock); #1;
            check_bit("bp_out_valid", out_valid, 1'b1);
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_word("bp_x_stable", x_out, cap_x);
            check_word("bp_y_stable", y_out, cap_y);
            check_word("bp_a_stable", angle_out, cap_a);
        end
        in_valid = 1'b0;
        release_out("bp", 1'b0);
        repeat (LAT + 3) @(posedge clock);
        #1;
        check_bit("bp_no_phantom", out_valid, 1'b0);

        // Vectoring, including the x<0 half-plane and the y=0 axis
        send("vec_3_4_5", 1'b0, 1'b1, 32'h2666_6666, 32'h3333_3333, 32'h0, g24, TOL, TOL_V, LAT);
        release_out("vec_3_4_5", 1'b0);
        send("vec_xneg", 1'b0, 1'b1, 32'hD000_0000, 32'h1000_0000, 32'h0, g24, TOL, TOL_V, LAT);
        release_out("vec_xneg", 1'b0);
        send("vec_axis", 1'b0, 1'b1, 32'h3000_0000, 32'h0, 32'h0, g24, TOL, TOL_V, LAT);
        release_out("vec_axis", 1'b0);

        // Rotation through the pre-rotated quadrant (135 degrees)
        send("rot_135", 1'b0, 1'b0, 32'h4000_0000, 32'h0, 32'h6000_0000, g24, TOL, TOL_A, LAT);
        release_out("rot_135", 1'b0);

        // Reset five cycles into a transaction discards it
        @(negedge clock);
        mode = 1'b0; x_in = 32'h4000_0000; y_in = '0; angle_in = 32'h2000_0000; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_bit("midrst_in_ready", in_ready, 1'b0);
        check_word("midrst_x_out", x_out, '0);
        check_word("midrst_y_out", y_out, '0);
        check_word("midrst_angle_out", angle_out, '0);
        reset = 1'b0;
        #1;
        check_bit("midrst_ready_after", in_ready, 1'b1);
        send("rot_45_rerun", 1'b0, 1'b0, 32'h4000_0000, 32'h0, 32'h2000_0000, g24, TOL, TOL_A, LAT);
        release_out("rot_45_rerun", 1'b0);

        // Short 8-iteration engine
        send("rot_45_it8", 1'b1, 1'b0, 32'h4000_0000, 32'h0, 32'h2000_0000, g8, TOL8, TOL8, LAT8);
        release_out("rot_45_it8", 1'b1);

        check_int("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
